// File: rtl/fetch_ram_wr_ctrl_if.sv
// Signal bundle between the fetch SRAM fill controller, the word source,
// the line reader and the single-port SRAM macro.
interface fetch_ram_wr_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 5
);
  logic              start_i;
  logic [5:0]        len_i;
  logic              ext_valid_i;
  logic [WORD_W-1:0] ext_data_i;
  logic              ext_ready_o;
  logic              busy_o;
  logic              done_o;
  logic [5:0]        lines_o;
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_gnt_o;
  logic              rd_valid_o;
  logic [LINE_W-1:0] rd_data_o;
  logic              ram_cen_o;
  logic              ram_oen_o;
  logic              ram_wen_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [LINE_W-1:0] ram_data_o;
  logic [LINE_W-1:0] ram_data_i;

  modport slave (
    input  start_i, len_i, ext_valid_i, ext_data_i, rd_req_i, rd_addr_i, ram_data_i,
    output ext_ready_o, busy_o, done_o, lines_o, rd_gnt_o, rd_valid_o, rd_data_o,
           ram_cen_o, ram_oen_o, ram_wen_o, ram_addr_o, ram_data_o
  );

  modport master (
    output start_i, len_i, ext_valid_i, ext_data_i, rd_req_i, rd_addr_i, ram_data_i,
    input  ext_ready_o, busy_o, done_o, lines_o, rd_gnt_o, rd_valid_o, rd_data_o,
           ram_cen_o, ram_oen_o, ram_wen_o, ram_addr_o, ram_data_o
  );
endinterface

// File: rtl/fetch_ram_wr_ctrl.sv
// Packs 32-bit fetch words into 128-bit lines and writes them to the fetch SRAM,
// sharing the single SRAM port with a line reader (writes take priority).
module fetch_ram_wr_ctrl #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  fetch_ram_wr_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [5:0]        r_len;
  logic [5:0]        r_lines;
  logic [5:0]        r_lines_pack;
  logic [1:0]        r_word_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_wr_pend;
  logic [LINE_W-1:0] r_pack;
  logic [LINE_W-1:0] r_wr_line;
  logic              r_rd_valid;
  logic [LINE_W-1:0] w_pack_nxt;
  logic              w_ext_ready;
  logic              w_start;
  logic              w_accept;
  logic              w_rd_gnt;
  logic              w_last_wr;

  assign w_ext_ready = (r_state == S_FILL) && (r_lines_pack < r_len);
  assign w_start     = bus.start_i && (r_state != S_DONE);
  // A word presented alongside a restart belongs to the abandoned fill.
  assign w_accept    = bus.ext_valid_i && w_ext_ready && !w_start;
  assign w_rd_gnt    = bus.rd_req_i && !r_wr_pend;
  assign w_last_wr   = r_wr_pend && (r_lines == (r_len - 6'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) w_state_nxt = (bus.len_i == 6'd0) ? S_DONE : S_FILL;
        else             w_state_nxt = S_IDLE;
      end
      S_FILL: begin
        if (bus.start_i)    w_state_nxt = (bus.len_i == 6'd0) ? S_DONE : S_FILL;
        else if (w_last_wr) w_state_nxt = S_DONE;
        else                w_state_nxt = S_FILL;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pack_nxt = r_pack;
    w_pack_nxt[LINE_W-1-WORD_W*int'(r_word_cnt) -: WORD_W] = bus.ext_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len        <= 6'd0;
      r_lines      <= 6'd0;
      r_lines_pack <= 6'd0;
      r_word_cnt   <= 2'd0;
      r_wr_addr    <= '0;
      r_wr_pend    <= 1'b0;
      r_pack       <= '0;
      r_wr_line    <= '0;
    end else begin
      if (r_wr_pend) begin
        r_wr_pend <= 1'b0;
        r_wr_addr <= r_wr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        r_lines   <= r_lines + 6'd1;
      end
      // Restart overrides the count update of a write issued this same cycle.
      if (w_start) begin
        r_len        <= bus.len_i;
        r_lines      <= 6'd0;
        r_lines_pack <= 6'd0;
        r_word_cnt   <= 2'd0;
        r_wr_addr    <= '0;
        r_pack       <= '0;
      end else if (w_accept) begin
        r_word_cnt <= r_word_cnt + 2'd1;
        if (r_word_cnt == 2'd3) begin
          r_wr_line    <= w_pack_nxt;
          r_wr_pend    <= 1'b1;
          r_lines_pack <= r_lines_pack + 6'd1;
          r_pack       <= '0;
        end else begin
          r_pack <= w_pack_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_valid <= 1'b0;
    else     r_rd_valid <= w_rd_gnt;
  end

  always_comb begin
    bus.ram_cen_o  = 1'b1;
    bus.ram_wen_o  = 1'b1;
    bus.ram_addr_o = '0;
    bus.ram_data_o = '0;
    if (r_wr_pend) begin
      bus.ram_cen_o  = 1'b0;
      bus.ram_wen_o  = 1'b0;
      bus.ram_addr_o = r_wr_addr;
      bus.ram_data_o = r_wr_line;
    end else if (w_rd_gnt) begin
      bus.ram_cen_o  = 1'b0;
      bus.ram_addr_o = bus.rd_addr_i;
    end else begin
      bus.ram_cen_o  = 1'b1;
    end
  end

  assign bus.ram_oen_o   = 1'b0;
  assign bus.ext_ready_o = w_ext_ready;
  assign bus.busy_o      = (r_state == S_FILL);
  assign bus.done_o      = (r_state == S_DONE);
  assign bus.lines_o     = r_lines;
  assign bus.rd_gnt_o    = w_rd_gnt;
  assign bus.rd_valid_o  = r_rd_valid;
  // SRAM read data arrives one cycle after the grant, aligned with rd_valid_o.
  assign bus.rd_data_o   = r_rd_valid ? bus.ram_data_i : '0;

endmodule

// File: tb/tb_fetch_ram_wr_ctrl.sv
// Scoreboard bench for fetch_ram_wr_ctrl: stimulus pushes expected SRAM writes,
// done pulses and read returns; a negedge monitor pops and compares them.
module tb_fetch_ram_wr_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_ram_wr_ctrl_if bus ();
  fetch_ram_wr_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int cyc; logic [4:0] addr; logic [127:0] data; } wr_exp_t;
  typedef struct { int cyc; logic [5:0] lines; } done_exp_t;
  typedef struct { int cyc; logic [127:0] data; } rd_exp_t;

  wr_exp_t   wr_q[$];
  done_exp_t done_q[$];
  rd_exp_t   rd_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_mode = 0;

  logic [127:0] sram [32];
  logic [127:0] sram_q;
  logic [127:0] ref_mem [32];

  logic [31:0] words_q[$];
  int          line_no;
  int          fill_len;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro model, one-cycle read latency; seeded with a known pattern.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 32; i++) sram[i] <= {4{32'hA5A50000 + 32'(i)}};
    end else if (!bus.ram_cen_o) begin
      if (!bus.ram_wen_o) sram[bus.ram_addr_o] <= bus.ram_data_o;
      else                sram_q <= sram[bus.ram_addr_o];
    end
  end
  assign bus.ram_data_i = sram_q;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reader stimulus changes just after the rising edge so the monitor sees it settled.
  initial begin
    bus.rd_req_i  = 1'b0;
    bus.rd_addr_i = 5'd0;
    forever begin
      @(posedge clk);
      #2;
      case (rd_mode)
        1:       begin bus.rd_req_i = 1'b1; bus.rd_addr_i = 5'd0; end
        2:       begin bus.rd_req_i = 1'($urandom_range(0, 1)); bus.rd_addr_i = 5'($urandom_range(0, 31)); end
        default: begin bus.rd_req_i = 1'b0; bus.rd_addr_i = 5'd0; end
      endcase
    end
  end

  // Monitor: every SRAM write, grant, read return and done pulse must match an expectation.
  initial begin
    logic      wr_now;
    wr_exp_t   we;
    rd_exp_t   re;
    done_exp_t de;
    for (int i = 0; i < 32; i++) ref_mem[i] = {4{32'hA5A50000 + 32'(i)}};
    forever begin
      @(negedge clk);
      if (!rst) begin
        wr_now = !bus.ram_cen_o && !bus.ram_wen_o;
        if (wr_now) begin
          if (wr_q.size() == 0) chk("unexpected_write", 128'(bus.ram_addr_o), 128'h1_0000);
          else begin
            we = wr_q.pop_front();
            chk("wr_cycle", 128'(cyc), 128'(we.cyc));
            chk("wr_addr", 128'(bus.ram_addr_o), 128'(we.addr));
            chk("wr_data", bus.ram_data_o, we.data);
            ref_mem[we.addr] = we.data;
          end
        end
        if (bus.rd_req_i) begin
          chk("rd_gnt", 128'(bus.rd_gnt_o), 128'(!wr_now));
          if (bus.rd_gnt_o) begin
            chk("rd_port", {bus.ram_cen_o, bus.ram_wen_o, bus.ram_addr_o}, {1'b0, 1'b1, bus.rd_addr_i});
            rd_q.push_back('{cyc + 1, ref_mem[bus.rd_addr_i]});
          end
        end else begin
          chk("rd_gnt_idle", 128'(bus.rd_gnt_o), 128'd0);
        end
        if (bus.rd_valid_o) begin
          if (rd_q.size() == 0) chk("unexpected_rd_valid", 128'd1, 128'd0);
          else begin
            re = rd_q.pop_front();
            chk("rd_cycle", 128'(cyc), 128'(re.cyc));
            chk("rd_data", bus.rd_data_o, re.data);
          end
        end
        if (bus.done_o) begin
          if (done_q.size() == 0) chk("unexpected_done", 128'd1, 128'd0);
          else begin
            de = done_q.pop_front();
            chk("done_cycle", 128'(cyc), 128'(de.cyc));
            chk("done_lines", 128'(bus.lines_o), 128'(de.lines));
          end
        end
      end
    end
  end

  task automatic start_fill(input int len);
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.len_i       = 6'(len);
    bus.ext_valid_i = 1'b0;
    fill_len        = len;
    line_no         = 0;
    words_q.delete();
    if (len == 0) done_q.push_back('{cyc + 1, 6'd0});
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // Reference model: four accepted words form one line, first word in the top bits.
  task automatic record(input logic [31:0] w, input int k);
    words_q.push_back(w);
    if (words_q.size() == 4) begin
      wr_q.push_back('{k + 1, 5'(line_no), {words_q[0], words_q[1], words_q[2], words_q[3]}});
      line_no++;
      words_q.delete();
      if (line_no == fill_len) done_q.push_back('{k + 2, 6'(fill_len)});
    end
  endtask

  task automatic send_words(input int n, input int gap_pct, input logic rnd, input logic [31:0] base);
    int waited;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      forever begin
        @(negedge clk);
        if ($urandom_range(0, 99) < gap_pct) begin
          bus.ext_valid_i = 1'b0;
        end else begin
          bus.ext_valid_i = 1'b1;
          bus.ext_data_i  = rnd ? $urandom : base + 32'(i);
          if (bus.ext_ready_o) begin
            record(bus.ext_data_i, cyc);
            break;
          end
        end
        waited++;
        if (waited > 200) begin
          chk("word_timeout", 128'(i), 128'(n));
          return;
        end
      end
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    bus.ext_valid_i = 1'b0;
  endtask

  task automatic check_no_ready(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ext_valid_i = 1'b1;
      bus.ext_data_i  = 32'hDEAD0000 + 32'(i);
      chk("no_ready", 128'(bus.ext_ready_o), 128'd0);
    end
    bus.ext_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.start_i     = 1'b0;
    bus.len_i       = 6'd0;
    bus.ext_valid_i = 1'b0;
    bus.ext_data_i  = 32'd0;
    line_no         = 0;
    fill_len        = 0;
    idle(3);
    chk("rst_status", {bus.busy_o, bus.done_o, bus.ext_ready_o, bus.rd_valid_o}, 4'b0000);
    chk("rst_lines", 128'(bus.lines_o), 128'd0);
    chk("rst_ram_ctl", {bus.ram_cen_o, bus.ram_wen_o, bus.ram_oen_o}, 3'b110);
    chk("rst_ram_addr", 128'(bus.ram_addr_o), 128'd0);
    chk("rst_ram_data", bus.ram_data_o, 128'd0);
    chk("rst_rd_data", bus.rd_data_o, 128'd0);
    rst = 1'b0;
    idle(2);

    // Two lines back-to-back while a reader hammers line 0.
    rd_mode = 1;
    start_fill(2);
    send_words(8, 0, 1'b0, 32'd1);
    drop_valid();
    idle(6);
    chk("lines_after_2", 128'(bus.lines_o), 128'd2);
    rd_mode = 0;
    idle(3);

    // Full 32-line fill with random gaps and random reads.
    rd_mode = 2;
    start_fill(32);
    send_words(128, 30, 1'b1, 32'd0);
    check_no_ready(4);
    idle(6);
    chk("lines_after_32", 128'(bus.lines_o), 128'd32);
    rd_mode = 0;
    idle(3);

    // Empty fill.
    start_fill(0);
    check_no_ready(3);
    idle(4);

    // Restart after six words of a four-line fill.
    start_fill(4);
    send_words(6, 0, 1'b0, 32'd100);
    start_fill(4);
    chk("lines_restart", 128'(bus.lines_o), 128'd0);
    rd_mode = 2;
    send_words(16, 10, 1'b0, 32'd200);
    drop_valid();
    idle(6);
    rd_mode = 0;
    idle(3);

    // Reset while a line write is pending: the write must vanish.
    start_fill(2);
    send_words(4, 0, 1'b0, 32'd300);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.ext_valid_i = 1'b0;
    wr_q.delete();
    done_q.delete();
    rd_q.delete();
    #1;
    chk("rst_mid_ctl", {bus.ram_cen_o, bus.ram_wen_o, bus.busy_o}, 3'b110);
    idle(2);
    rst = 1'b0;
    idle(8);

    // Recovery: one more short fill after the reset.
    rd_mode = 2;
    start_fill(1);
    send_words(4, 20, 1'b1, 32'd0);
    drop_valid();
    idle(6);
    rd_mode = 0;
    idle(4);

    chk("wr_q_empty", 128'(wr_q.size()), 128'd0);
    chk("done_q_empty", 128'(done_q.size()), 128'd0);
    chk("rd_q_empty", 128'(rd_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ram_wr_ctrl.md
Name: fetch_ram_wr_ctrl

Overview:
- Fill/arbitration controller placed directly in front of the 32-entry x 128-bit single-port fetch SRAM.
- Accepts a 32-bit word stream from the external fetch interface and packs 4 words into each 128-bit line.
- Writes lines to consecutive SRAM addresses starting at 0.
- Shares the single SRAM port with a downstream line reader, with write priority.

Parameters:
- WORD_W, 32: external word width.
- LINE_W, 128: SRAM line width; must equal 4*WORD_W.
- ADDR_W, 5: SRAM address width (32 lines).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  pulse: begin new fill of len_i lines at address 0.
- len_i  in  6  lines to fill, 0..32; sampled on start_i.
- ext_valid_i  in  1  external word valid.
- ext_data_i  in  WORD_W  external word.
- ext_ready_o  out  1  word accepted when valid&ready.
- busy_o  out  1  fill in progress.
- done_o  out  1  one-cycle pulse, fill complete.
- lines_o  out  6  lines written in current fill.
- rd_req_i  in  1  reader requests line rd_addr_i.
- rd_addr_i  in  ADDR_W  read line address.
- rd_gnt_o  out  1  read issued to SRAM this cycle.
- rd_valid_o  out  1  rd_data_o valid (granted read + 1 cycle).
- rd_data_o  out  LINE_W  read line.
- ram_cen_o  out  1  SRAM chip enable, low active.
- ram_oen_o  out  1  SRAM output enable, low active.
- ram_wen_o  out  1  SRAM write enable, low active.
- ram_addr_o  out  ADDR_W  SRAM address.
- ram_data_o  out  LINE_W  SRAM write data.
- ram_data_i  in  LINE_W  SRAM read data (1-cycle latency).

Behaviour:
- FSM states: IDLE, FILL, DONE.
  - IDLE -> FILL on start_i when len_i != 0.
  - IDLE -> DONE on start_i when len_i == 0.
  - FILL -> DONE when the SRAM write of line len_i-1 is issued.
  - DONE -> IDLE unconditionally after 1 cycle.
- Reset values:
  - FSM = IDLE; word_cnt, line counter, wr_addr, lines_o = 0.
  - wr_pend = 0; ext_ready_o, busy_o, done_o, rd_gnt_o, rd_valid_o = 0.
  - ram_cen_o = 1, ram_wen_o = 1, ram_oen_o = 0.
  - ram_addr_o = 0, ram_data_o = 0, rd_data_o = 0.
- Status outputs:
  - busy_o = (state == FILL).
  - done_o = (state == DONE).
  - ext_ready_o = (state == FILL) && lines still to pack.
- Packing (MSB first):
  - Word k (k = 0..3) of a line goes to pack[LINE_W-1-WORD_W*k -: WORD_W].
  - word_cnt wraps 3 -> 0.
  - On the 4th accepted word, the full line (including that word) is copied into wr_line, wr_pend is set, and wr_addr is held.
- Write port:
  - While wr_pend: ram_cen_o = 0, ram_wen_o = 0, ram_addr_o = wr_addr, ram_data_o = wr_line.
  - At the end of that cycle: wr_pend clears, wr_addr and lines_o increment.
  - Latency: 4th word accepted in cycle T -> SRAM write in T+1 -> lines_o updated in T+2.
  - For the last line, DONE occupies T+2.
- Read port:
  - rd_gnt_o = rd_req_i && !wr_pend (combinational); write always wins.
  - On grant: ram_cen_o = 0, ram_wen_o = 1, ram_addr_o = rd_addr_i.
  - rd_valid_o is registered one cycle later; rd_data_o = ram_data_i in that cycle.
  - Reads are allowed in any state.
  - Reading a line not yet written returns stale SRAM contents and is not an error.
- Idle port: ram_cen_o = 1 when neither a write nor a read is issued. ram_oen_o is tied 0.
- Throughput:
  - wr_pend lasts exactly one cycle, so ext_ready_o never drops mid-fill.
  - A reader can be blocked at most 1 of every 4 cycles during full-rate fill.
- start_i while in FILL (restart):
  - Partial pack and word_cnt are discarded; counters restart at 0.
  - An already-pending write still completes at its captured address but is not counted.
- start_i in DONE is ignored.
- Reset asserted mid-fill: asynchronous return to reset values; any pending write is dropped.

Test Plan:
- Reset, start_i with len_i=2, 8 words 0x00000001..0x00000008 back-to-back:
  - Write addr0 data 0x00000001_00000002_00000003_00000004.
  - Write addr1 data 0x00000005_00000006_00000007_00000008.
  - Single done_o pulse 2 cycles after the 8th word; lines_o=2.
- Read collision: rd_req_i held with rd_addr_i=0 during fill:
  - rd_gnt_o=0 exactly in write cycles.
  - rd_valid_o one cycle after each grant, carrying the line-0 contents once written.
- len_i=32 with random ext_valid_i gaps:
  - 32 writes to addresses 0..31, no address wrap, ext_ready_o=0 after the 128th word.
  - done_o once.
- len_i=0:
  - done_o asserted the cycle after start_i.
  - No SRAM write, ext_ready_o stays 0.
- start_i after 6 words of a len_i=4 fill:
  - Line 0 already written.
  - Words 5-6 discarded; new fill writes addr0 again; lines_o restarts at 0.
- rst pulsed while wr_pend=1:
  - Same cycle: ram_cen_o=1, ram_wen_o=1, busy_o=0.
  - No write occurs afterward.
